// File: rtl/reg_dest_scoreboard.sv
// Destination-register scoreboard: tracks in-flight register writes between issue and
// write-back, and stalls issue on RAW hazards or a saturated per-register counter.
module reg_dest_scoreboard #(
  parameter int AW = 5,
  parameter int CW = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Flush,
  input  logic              Issue_Valid,
  input  logic              Issue_RegWrite,
  input  logic [AW-1:0]     Issue_Dst,
  input  logic [AW-1:0]     Issue_Rs,
  input  logic [AW-1:0]     Issue_Rt,
  output logic              Stall,
  input  logic              WB_Valid,
  input  logic [AW-1:0]     WB_Dst,
  output logic [2**AW-1:0]  Pending,
  output logic              Error
);

  localparam int NREGS = 2**AW;
  localparam logic [CW-1:0] CMAX = '1;

  logic [CW-1:0]    cnt_p0  [NREGS];
  logic [CW-1:0]    cnt_nxt [NREGS];
  logic [NREGS-1:0] pend_nxt;
  logic [NREGS-1:0] inc_v;
  logic [NREGS-1:0] dec_v;
  logic             err_nxt;
  logic             haz_rs;
  logic             haz_rt;
  logic             full;
  logic             accept;

  // Hazard detection looks only at registered counts; a same-cycle write-back is not bypassed.
  always_comb begin
    haz_rs = (Issue_Rs  != '0) && (cnt_p0[Issue_Rs]  != '0);
    haz_rt = (Issue_Rt  != '0) && (cnt_p0[Issue_Rt]  != '0);
    full   = Issue_RegWrite && (Issue_Dst != '0) && (cnt_p0[Issue_Dst] == CMAX);
    Stall  = Issue_Valid && (haz_rs || haz_rt || full);
    accept = Issue_Valid && !Stall;
  end

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int r = 1; r < NREGS; r++) begin
      inc_v[r] = accept && Issue_RegWrite && (Issue_Dst == AW'(r));
      dec_v[r] = WB_Valid && (WB_Dst == AW'(r)) && (cnt_p0[r] != '0);
    end
  end

  always_comb begin
    cnt_nxt  = cnt_p0;
    pend_nxt = '0;
    err_nxt  = Error;
    cnt_nxt[0] = '0;
    for (int r = 1; r < NREGS; r++) begin
      if (inc_v[r] && !dec_v[r]) begin
        cnt_nxt[r] = cnt_p0[r] + 1'b1;
      end else if (dec_v[r] && !inc_v[r]) begin
        cnt_nxt[r] = cnt_p0[r] - 1'b1;
      end
    end
    // Flush wipes all in-flight state but leaves the sticky error alone.
    if (Flush) begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_nxt[r] = '0;
      end
    end
    for (int r = 0; r < NREGS; r++) begin
      pend_nxt[r] = (cnt_nxt[r] != '0);
    end
    if (WB_Valid && (WB_Dst != '0) && (cnt_p0[WB_Dst] == '0)) begin
      err_nxt = 1'b1;
    end
  end

  // Counter / status register stage
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_p0  <= '{default: '0};
      Pending <= '0;
      Error   <= 1'b0;
    end else begin
      cnt_p0  <= cnt_nxt;
      Pending <= pend_nxt;
      Error   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_reg_dest_scoreboard.sv
// Directed bench for reg_dest_scoreboard with a per-register pending-count reference
// model checked every cycle, plus hand-computed literal checks.
module tb_reg_dest_scoreboard;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Flush;
  logic        Issue_Valid;
  logic        Issue_RegWrite;
  logic [4:0]  Issue_Dst;
  logic [4:0]  Issue_Rs;
  logic [4:0]  Issue_Rt;
  logic        Stall;
  logic        WB_Valid;
  logic [4:0]  WB_Dst;
  logic [31:0] Pending;
  logic        Error;

  int n_checks = 0;
  int n_fail   = 0;

  int cnt_m [32];
  bit err_m;

  reg_dest_scoreboard #(.AW(5), .CW(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Flush(Flush),
    .Issue_Valid(Issue_Valid), .Issue_RegWrite(Issue_RegWrite),
    .Issue_Dst(Issue_Dst), .Issue_Rs(Issue_Rs), .Issue_Rt(Issue_Rt),
    .Stall(Stall), .WB_Valid(WB_Valid), .WB_Dst(WB_Dst),
    .Pending(Pending), .Error(Error)
  );

  always #5 Clk = ~Clk;

  function automatic bit model_stall();
    bit haz;
    haz = 1'b0;
    if (Issue_Rs != 0 && cnt_m[Issue_Rs] > 0) haz = 1'b1;
    if (Issue_Rt != 0 && cnt_m[Issue_Rt] > 0) haz = 1'b1;
    if (Issue_RegWrite && Issue_Dst != 0 && cnt_m[Issue_Dst] == 3) haz = 1'b1;
    return Issue_Valid && haz;
  endfunction

  function automatic logic [31:0] model_pending();
    logic [31:0] p;
    p = '0;
    for (int r = 1; r < 32; r++) p[r] = (cnt_m[r] > 0);
    return p;
  endfunction

  // Reference model: counts per register, updated from the rules directly.
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int r = 0; r < 32; r++) cnt_m[r] = 0;
      err_m = 1'b0;
    end else begin
      int  old_wb;
      bit  acc;
      acc    = Issue_Valid && !model_stall();
      old_wb = cnt_m[WB_Dst];
      if (WB_Valid && WB_Dst != 0 && old_wb == 0) err_m = 1'b1;
      if (acc && Issue_RegWrite && Issue_Dst != 0) cnt_m[Issue_Dst] = cnt_m[Issue_Dst] + 1;
      if (WB_Valid && WB_Dst != 0 && old_wb > 0) cnt_m[WB_Dst] = cnt_m[WB_Dst] - 1;
      if (Flush) for (int r = 0; r < 32; r++) cnt_m[r] = 0;
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge Clk) begin
    n_checks++;
    if (Pending !== model_pending()) begin
      n_fail++;
      $display("FAIL model_pending t=%0t got=%h exp=%h", $time, Pending, model_pending());
    end
    n_checks++;
    if (Error !== err_m) begin
      n_fail++;
      $display("FAIL model_error t=%0t got=%b exp=%b", $time, Error, err_m);
    end
    n_checks++;
    if (Stall !== model_stall()) begin
      n_fail++;
      $display("FAIL model_stall t=%0t got=%b exp=%b", $time, Stall, model_stall());
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #2;
  endtask

  task automatic iss(input logic v, input logic rw, input logic [4:0] d,
                     input logic [4:0] rs, input logic [4:0] rt);
    Issue_Valid = v; Issue_RegWrite = rw; Issue_Dst = d; Issue_Rs = rs; Issue_Rt = rt;
  endtask

  task automatic wb(input logic v, input logic [4:0] d);
    WB_Valid = v; WB_Dst = d;
  endtask

  initial begin
    Reset_n = 1'b0; Flush = 1'b0;
    iss(0, 0, 0, 0, 0);
    wb(0, 0);
    cyc(); cyc();
    chk("reset_pending", Pending, 32'h0);
    chk("reset_error", {31'b0, Error}, 32'h0);
    Reset_n = 1'b1;
    cyc();

    // RAW interlock on r9
    iss(1, 1, 9, 0, 0); #1;
    chk("raw_first_stall", {31'b0, Stall}, 32'h0);
    cyc();
    chk("raw_pending9", {31'b0, Pending[9]}, 32'h1);
    iss(1, 0, 0, 9, 0); #1;
    chk("raw_stall_c1", {31'b0, Stall}, 32'h1);
    cyc();
    chk("raw_stall_c2", {31'b0, Stall}, 32'h1);
    cyc();
    wb(1, 9); #1;
    chk("raw_stall_wb_cycle", {31'b0, Stall}, 32'h1);
    cyc();
    wb(0, 0); #1;
    chk("raw_release", {31'b0, Stall}, 32'h0);
    chk("raw_pending9_clr", {31'b0, Pending[9]}, 32'h0);
    cyc();

    // Rt hazard
    iss(1, 1, 10, 0, 0); cyc();
    iss(1, 0, 0, 0, 10); #1;
    chk("rt_stall", {31'b0, Stall}, 32'h1);
    iss(0, 0, 0, 0, 0); wb(1, 10); cyc();
    wb(0, 0); cyc();

    // Saturation on r5
    iss(1, 1, 5, 0, 0); cyc(); cyc(); cyc();
    #1;
    chk("sat_pending", Pending, 32'h0000_0020);
    chk("sat_stall", {31'b0, Stall}, 32'h1);
    wb(1, 5); #1;
    chk("sat_stall_wb", {31'b0, Stall}, 32'h1);
    cyc();
    wb(0, 0); #1;
    chk("sat_accept", {31'b0, Stall}, 32'h0);
    cyc();
    #1;
    chk("sat_full_again", {31'b0, Stall}, 32'h1);
    iss(0, 0, 0, 0, 0);
    wb(1, 5); cyc(); cyc(); cyc();
    wb(0, 0); #1;
    chk("sat_drained", Pending, 32'h0);

    // Simultaneous inc/dec on r7
    iss(1, 1, 7, 0, 0); cyc();
    wb(1, 7); cyc();
    iss(0, 0, 0, 0, 0); wb(0, 0); #1;
    chk("simul_pending7", {31'b0, Pending[7]}, 32'h1);
    wb(1, 7); cyc();
    wb(0, 0); #1;
    chk("simul_drained", Pending, 32'h0);

    // Register 0 and sticky error
    iss(1, 1, 0, 0, 0); cyc();
    iss(0, 0, 0, 0, 0); #1;
    chk("r0_pending", Pending, 32'h0);
    iss(1, 1, 11, 0, 0); cyc();
    iss(1, 0, 0, 0, 0); #1;
    chk("r0_no_stall", {31'b0, Stall}, 32'h0);
    iss(0, 0, 0, 0, 0); wb(1, 11); cyc();
    wb(1, 12); cyc();
    wb(0, 0); #1;
    chk("err_set", {31'b0, Error}, 32'h1);
    iss(1, 1, 13, 0, 0); cyc();
    iss(0, 0, 0, 0, 0); wb(1, 13); cyc();
    wb(0, 0); #1;
    chk("err_sticky", {31'b0, Error}, 32'h1);

    // Flush overrides same-cycle issue
    iss(1, 1, 3, 0, 0); cyc();
    iss(1, 1, 4, 0, 0); cyc(); cyc();
    #1;
    chk("flush_pre", Pending, 32'h0000_0018);
    iss(1, 1, 3, 0, 0); Flush = 1'b1; #1;
    chk("flush_accept", {31'b0, Stall}, 32'h0);
    cyc();
    Flush = 1'b0; iss(0, 0, 0, 0, 0); #1;
    chk("flush_pending", Pending, 32'h0);
    chk("flush_err_kept", {31'b0, Error}, 32'h1);

    // Asynchronous reset with r8 at count 2
    iss(1, 1, 8, 0, 0); cyc(); cyc();
    iss(0, 0, 0, 0, 0); #1;
    chk("rst_pre", {31'b0, Pending[8]}, 32'h1);
    Reset_n = 1'b0; #1;
    chk("rst_async_pending", Pending, 32'h0);
    chk("rst_async_error", {31'b0, Error}, 32'h0);
    cyc();
    Reset_n = 1'b1;
    cyc();
    iss(1, 0, 0, 8, 0); #1;
    chk("rst_no_stall", {31'b0, Stall}, 32'h0);
    cyc();
    iss(0, 0, 0, 0, 0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
